// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider: registered tick strobe and 50% clk_out square wave.
// Optional synchronous clear port is enabled by defining CLKDIV_SYNC_CLR_EN.
module clk_div_prog #(
  parameter int DIV_WIDTH = 24,
  parameter int RESET_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div_in,
`ifdef CLKDIV_SYNC_CLR_EN
  input  logic                 sync_clr,
`endif
  output logic                 tick,
  output logic                 clk_out,
  output logic                 pending,
  output logic                 load_err,
  output logic [DIV_WIDTH-1:0] count
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic                 tick_q, tick_d;
  logic                 clk_out_q, clk_out_d;
  logic                 load_err_q, load_err_d;

  logic [DIV_WIDTH-1:0] div_m1;
  logic                 tc;
  logic                 load_ok;

  assign div_m1  = div_q - ONE;
  // ">=" folds the out-of-range recovery case into the normal terminal count.
  assign tc      = en & (cnt_q >= div_m1);
  assign load_ok = load & (div_in != '0);

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    load_err_d = load & (div_in == '0);

    if (en) begin
      if (tc) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        pend_d    = 1'b0;
        if (load_ok) begin
          div_d = div_in;
        end else if (pend_q) begin
          div_d = pend_val_q;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        if (load_ok) begin
          pend_val_d = div_in;
          pend_d     = 1'b1;
        end
      end
    end else if (load_ok) begin
      div_d  = div_in;
      cnt_d  = '0;
      pend_d = 1'b0;
    end

`ifdef CLKDIV_SYNC_CLR_EN
    if (sync_clr) begin
      cnt_d      = '0;
      div_d      = div_q;
      pend_val_d = '0;
      pend_d     = 1'b0;
      tick_d     = 1'b0;
      clk_out_d  = 1'b0;
      load_err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      load_err_q <= load_err_d;
    end
  end

  assign tick     = tick_q;
  assign clk_out  = clk_out_q;
  assign pending  = pend_q;
  assign load_err = load_err_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: vector table plus hand-written multi-cycle sequences.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [23:0] div_in;
  logic        sync_clr;
  logic        tick, clk_out, pending, load_err;
  logic [23:0] count;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.DIV_WIDTH(24), .RESET_DIV(1000)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .div_in   (div_in),
`ifdef CLKDIV_SYNC_CLR_EN
    .sync_clr (sync_clr),
`endif
    .tick     (tick),
    .clk_out  (clk_out),
    .pending  (pending),
    .load_err (load_err),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e;
    logic        l;
    logic [23:0] d;
    logic        x_tick;
    logic [23:0] x_cnt;
    logic        x_pend;
    logic        x_lerr;
    logic        x_clk;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic e, input logic l, input int d, input logic t,
                              input int c, input logic p, input logic le, input logic k);
    vec_t v;
    v.e = e; v.l = l; v.d = d[23:0];
    v.x_tick = t; v.x_cnt = c[23:0]; v.x_pend = p; v.x_lerr = le; v.x_clk = k;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic l, input int d);
    en = e; load = l; div_in = d[23:0];
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic t, input int c, input logic p,
                         input logic le, input logic k);
    chk({tag, ".tick"},     32'(tick),     32'(t));
    chk({tag, ".count"},    32'(count),    32'(c));
    chk({tag, ".pending"},  32'(pending),  32'(p));
    chk({tag, ".load_err"}, 32'(load_err), 32'(le));
    chk({tag, ".clk_out"},  32'(clk_out),  32'(k));
  endtask

  int n_ticks;

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; div_in = '0; sync_clr = 1'b0;

    // Entry state for the table: cnt=0, div=5, clk_out=0 (after test 2)
    tbl[0]  = mk(1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 9, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, 1'b1, 3, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(1'b1, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk(1'b1, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0, 1'b1);

    // Test 1: reset values, then 4000 enabled cycles at the reset divisor
    #22;
    chk_all("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; en = 1'b1;
    n_ticks = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk); #1;
      if (tick) n_ticks++;
      chk("t1.tick",  32'(tick),  32'((k % 1000) == 0));
      chk("t1.count", 32'(count), 32'(k % 1000));
      chk("t1.clk_out", 32'(clk_out), 32'((k / 1000) % 2));
    end
    chk("t1.n_ticks", 32'(n_ticks), 32'(4));

    // Test 2: load 5 at cnt=300, applied at the 999 -> 0 terminal count
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 0);
    chk("t2.count300", 32'(count), 32'(300));
    step(1'b1, 1'b1, 5);
    chk_all("t2.load", 1'b0, 301, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 698; k++) step(1'b1, 1'b0, 0);
    chk_all("t2.wait", 1'b0, 999, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0);
    chk_all("t2.apply", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 0);
      chk("t2.tick5",  32'(tick),  32'(k == 5));
      chk("t2.count5", 32'(count), 32'(k % 5));
    end
    chk("t2.clk_out", 32'(clk_out), 32'(0));

    // Test 3: load on tc, then double load before the next tc
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].e, tbl[i].l, int'(tbl[i].d));
      chk_all($sformatf("vec%0d", i), tbl[i].x_tick, int'(tbl[i].x_cnt),
              tbl[i].x_pend, tbl[i].x_lerr, tbl[i].x_clk);
    end

    // Test 4: hold with en=0, load while disabled, re-enable
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 0);
      chk("t4.hold_cnt",  32'(count), 32'(2));
      chk("t4.hold_tick", 32'(tick),  32'(0));
    end
    step(1'b0, 1'b1, 4);
    chk_all("t4.dis_load", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 0);
      chk("t4.tick",  32'(tick),  32'(k == 4));
      chk("t4.count", 32'(count), 32'(k % 4));
    end
    chk("t4.clk_out", 32'(clk_out), 32'(0));

    // Test 5: zero-divisor load is rejected; then divide-by-one
    step(1'b1, 1'b1, 0);
    chk_all("t5.err", 1'b0, 1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0);
    chk_all("t5.err_end", 1'b0, 2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk_all("t5.div4_kept", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1);
    chk_all("t5.load1", 1'b0, 1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 0);
    chk_all("t5.err_pend", 1'b0, 2, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 0);
    chk_all("t5.pend_kept", 1'b0, 3, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0);
    chk_all("t5.apply1", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 0);
      chk_all("t5.div1", 1'b1, 0, 1'b0, 1'b0, logic'(k % 2));
    end

    // Test 6: async reset between edges at cnt=600
    step(1'b0, 1'b1, 1000);
    chk_all("t6.dis_load", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 599; k++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    chk_all("t6.pre", 1'b0, 600, 1'b1, 1'b0, 1'b1);
    #3 reset = 1'b1;
    #1;
    chk_all("t6.async", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("t6.held", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    n_ticks = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (tick) n_ticks++;
      chk("t6.tick",  32'(tick),  32'(k == 1000));
      chk("t6.count", 32'(count), 32'(k % 1000));
    end
    chk("t6.n_ticks", 32'(n_ticks), 32'(1));
    chk("t6.clk_out", 32'(clk_out), 32'(1));

`ifdef CLKDIV_SYNC_CLR_EN
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 7);
    chk_all("t7.pend", 1'b0, 11, 1'b1, 1'b0, 1'b1);
    sync_clr = 1'b1;
    step(1'b1, 1'b1, 0);
    sync_clr = 1'b0;
    chk_all("t7.sync_clr", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 1000; k++) begin
      step(1'b1, 1'b0, 0);
      chk("t7.tick", 32'(tick), 32'(k == 1000));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
